// File: rtl/countup_timer.sv
// Count-up M:SS stopwatch with its own one-second prescaler and start/stop/clear control.
// Emits the same 12-bit BCD word as the countdown, so the existing display logic is reused.
module countup_timer #(
  parameter int TICKS_PER_SEC = 31500000
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic [11:0] Count_out,
  output logic        sec_tick,
  output logic        running,
  output logic        tc
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [11:0]   COUNT_MAX = 12'h959;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] prescaler;

  // Advance M:SS by one second; the caller guarantees the input is below 9:59.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd5) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4]  = 4'd0;
        r[11:8] = v[11:8] + 4'd1;
      end
    end
    return r;
  endfunction

  // The edge that takes stop in RUN still does RUN's counting work, so a stop on
  // the wrap cycle keeps its increment and partial seconds survive a pause.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      prescaler <= '0;
      Count_out <= 12'h000;
      sec_tick  <= 1'b0;
      running   <= 1'b0;
      tc        <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        prescaler <= '0;
        Count_out <= 12'h000;
        running   <= 1'b0;
        tc        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              state     <= RUN;
              prescaler <= '0;
              running   <= 1'b1;
            end
          end
          RUN: begin
            if (prescaler == PS_LAST) begin
              prescaler <= '0;
              if (Count_out == COUNT_MAX) begin
                state   <= DONE;
                running <= 1'b0;
                tc      <= 1'b1;
              end else begin
                Count_out <= bcd_inc(Count_out);
                sec_tick  <= 1'b1;
                if (stop) begin
                  state   <= PAUSE;
                  running <= 1'b0;
                end
              end
            end else begin
              prescaler <= prescaler + PW'(1);
              if (stop) begin
                state   <= PAUSE;
                running <= 1'b0;
              end
            end
          end
          PAUSE: begin
            if (start && !stop) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          DONE: begin
            running <= 1'b0;
            tc      <= 1'b1;
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
            tc      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countup_timer.sv
// Bench for countup_timer: directed scenarios plus random control pulses,
// checked every cycle against an elapsed-seconds model of the stopwatch.
module tb_countup_timer;

  localparam int TPS = 4;

  logic        clk;
  logic        resetN;
  logic        start;
  logic        stop;
  logic        clear;
  logic [11:0] Count_out;
  logic        sec_tick;
  logic        running;
  logic        tc;

  int testsRun;
  int testsFailed;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
  mstate_t mState;
  int      mSecs;
  int      mPhase;
  logic    mTick;

  countup_timer #(.TICKS_PER_SEC(TPS)) dut (
    .clk      (clk),
    .resetN   (resetN),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .Count_out(Count_out),
    .sec_tick (sec_tick),
    .running  (running),
    .tc       (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] toBcd(input int s);
    return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mState = M_IDLE;
    mSecs  = 0;
    mPhase = 0;
    mTick  = 1'b0;
  endtask

  // Stopwatch rules in terms of whole elapsed seconds and cycles into the current second.
  task automatic modelStep(input logic s, input logic p, input logic c);
    mTick = 1'b0;
    if (c) begin
      mState = M_IDLE;
      mSecs  = 0;
      mPhase = 0;
    end else begin
      case (mState)
        M_IDLE: if (s && !p) begin
          mState = M_RUN;
          mPhase = 0;
        end
        M_RUN: begin
          mPhase = mPhase + 1;
          if (mPhase == TPS) begin
            mPhase = 0;
            if (mSecs == 599) mState = M_DONE;
            else begin
              mSecs = mSecs + 1;
              mTick = 1'b1;
            end
          end
          if (p && mState == M_RUN) mState = M_PAUSE;
        end
        M_PAUSE: if (s && !p) mState = M_RUN;
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] modelVector();
    return {17'd0, toBcd(mSecs), mTick, mState == M_RUN, mState == M_DONE};
  endfunction

  function automatic logic [31:0] dutVector();
    return {17'd0, Count_out, sec_tick, running, tc};
  endfunction

  // Drive one cycle of control pulses, clock it, and compare against the model.
  task automatic applyStimulus(input logic s, input logic p, input logic c);
    start = s;
    stop  = p;
    clear = c;
    @(posedge clk);
    modelStep(s, p, c);
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    checkOutput("lockstep", dutVector(), modelVector());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    resetN = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    clear  = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_state", dutVector(), 32'd0);
    resetN = 1'b1;
    idle(3);
    checkOutput("idle_no_count", {20'd0, Count_out}, 32'h000);

    // First and second second after start.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("start_running", {31'd0, running}, 32'd1);
    idle(3);
    checkOutput("before_first_tick", {19'd0, Count_out, sec_tick}, {19'd0, 12'h000, 1'b0});
    idle(1);
    checkOutput("first_tick", {19'd0, Count_out, sec_tick}, {19'd0, 12'h001, 1'b1});
    idle(4);
    checkOutput("second_tick", {18'd0, Count_out, sec_tick, running}, {18'd0, 12'h002, 1'b1, 1'b1});

    // BCD carries out of the ones and tens digits.
    idle(7 * TPS);
    checkOutput("at_0_09", {20'd0, Count_out}, 32'h009);
    idle(TPS);
    checkOutput("carry_0_10", {20'd0, Count_out}, 32'h010);
    idle(49 * TPS);
    checkOutput("at_0_59", {20'd0, Count_out}, 32'h059);
    idle(TPS);
    checkOutput("carry_1_00", {20'd0, Count_out}, 32'h100);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clear_from_run", dutVector(), 32'd0);

    // Pause two cycles after the first tick; the partial second survives.
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(TPS);
    idle(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    idle(20);
    checkOutput("paused_hold", {19'd0, Count_out, running}, {19'd0, 12'h001, 1'b0});
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resume_running", {31'd0, running}, 32'd1);
    idle(1);
    checkOutput("resume_no_tick_yet", {20'd0, Count_out}, 32'h001);
    idle(1);
    checkOutput("resume_tick", {19'd0, Count_out, sec_tick}, {19'd0, 12'h002, 1'b1});

    // clear+start in RUN lands in IDLE at 0:00.
    applyStimulus(1'b1, 1'b0, 1'b1);
    idle(2 * TPS);
    checkOutput("clear_start_idle", dutVector(), 32'd0);

    // start+stop together in IDLE is ignored.
    applyStimulus(1'b1, 1'b1, 1'b0);
    idle(2 * TPS);
    checkOutput("start_stop_idle", dutVector(), 32'd0);

    // stop on the wrap cycle keeps the increment, then pauses.
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(TPS - 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("stop_on_wrap", {18'd0, Count_out, sec_tick, running}, {18'd0, 12'h001, 1'b1, 1'b0});
    idle(2 * TPS);
    checkOutput("stop_on_wrap_hold", {20'd0, Count_out}, 32'h001);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Saturation at 9:59.
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(599 * TPS);
    checkOutput("at_9_59", {19'd0, Count_out, running}, {19'd0, 12'h959, 1'b1});
    idle(TPS);
    checkOutput("saturate", dutVector(), {17'd0, 12'h959, 1'b0, 1'b0, 1'b1});
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(2 * TPS);
    checkOutput("done_ignores_start", dutVector(), {17'd0, 12'h959, 1'b0, 1'b0, 1'b1});
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clear_from_done", dutVector(), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("idle_after_done_clear", {31'd0, running}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Asynchronous reset between edges at 3:47.
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(227 * TPS);
    checkOutput("at_3_47", {20'd0, Count_out}, 32'h347);
    #2 resetN = 1'b0;
    #1 checkOutput("async_reset", dutVector(), 32'd0);
    modelReset();
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    idle(3 * TPS);
    checkOutput("after_reset_idle", dutVector(), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("after_reset_start", {31'd0, running}, 32'd1);

    // Random control pulses, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      logic s, p, c;
      s = ($urandom_range(0, 15) == 0);
      p = ($urandom_range(0, 19) == 0);
      c = ($urandom_range(0, 199) == 0);
      applyStimulus(s, p, c);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/countup_timer.md
Name: countup_timer

Overview:
- Elapsed-time stopwatch: the count-up counterpart of the game's M:SS countdown.
- Produces the same 12-bit BCD M:SS word ({min ones, sec tens, sec ones}) and a terminal flag, so existing display and 7-seg decode logic is reused unchanged.
- Contains its own one-second prescaler and a start/stop/clear control FSM.
- Sits beside the countdown in the VGA/game top level and times level completion.

Parameters:
- TICKS_PER_SEC, default 31500000: clk cycles per counted second (bench overrides to 4).

Ports:
- clk  input  1  system clock
- resetN  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse: begin or resume counting
- stop  input  1  one-cycle pulse: pause counting
- clear  input  1  one-cycle pulse: return to 0:00, idle
- Count_out  output  12  BCD elapsed time: [11:8] minutes 0-9, [7:4] second tens 0-5, [3:0] second ones 0-9
- sec_tick  output  1  one-cycle pulse on every cycle in which Count_out increments
- running  output  1  high while in RUN
- tc  output  1  high while saturated at 9:59 (DONE)

Behaviour:
- Reset:
  - Asynchronous, resetN low: state=IDLE, Count_out=12'h000, prescaler=0, sec_tick=0, running=0, tc=0.
  - Reset mid-run discards all progress.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Priority each cycle: clear > stop > start. clear from any state -> IDLE, Count_out=0, prescaler=0 on the next edge.
- IDLE:
  - start -> RUN, prescaler=0.
  - stop ignored.
- RUN:
  - Prescaler counts 0..TICKS_PER_SEC-1 and wraps.
  - On the edge where prescaler==TICKS_PER_SEC-1, Count_out increments by one second and sec_tick=1 for that cycle.
  - First increment lands exactly TICKS_PER_SEC cycles after the start edge.
  - stop -> PAUSE; prescaler holds its value.
  - If stop coincides with the wrap cycle, the increment still happens, then PAUSE.
  - start in RUN ignored.
- PAUSE:
  - Count and prescaler hold.
  - start -> RUN; the prescaler resumes from the held value, so partial seconds are not lost.
  - stop ignored.
- BCD increment:
  - Seconds ones 9->0 with carry into tens.
  - Tens 5->0 with carry into minutes.
  - Minutes 0-9.
  - No digit ever holds a non-BCD value, and tens never exceed 5.
- Saturation:
  - A tick at 9:59 (12'h959) leaves Count_out=12'h959 (no increment, no sec_tick) and enters DONE.
  - DONE: tc=1, running=0, start/stop ignored; only clear or reset exits.
- running=1 exactly in RUN; tc=1 exactly in DONE.
- Latency: control pulse to state/output change is 1 clk.

Test Plan:
- Reset, then start with TICKS_PER_SEC=4:
  - Count_out=12'h001 with sec_tick high 4 cycles after the start edge.
  - 12'h002 after 8 cycles.
  - running=1 throughout.
- Run through 0:09:
  - Next tick gives 12'h010.
  - From 0:59, next tick gives 12'h100.
  - No intermediate invalid BCD digit is ever visible.
- Pause/resume:
  - Start, stop 2 cycles after the first tick; hold 20 cycles with Count_out=12'h001 and running=0.
  - Start again: the next increment (12'h002) occurs 2 cycles after resume.
- Saturation:
  - Run to 12'h959; the next prescaler wrap leaves 12'h959, sec_tick=0, tc=1, running=0.
  - A start pulse then has no effect.
  - clear -> 12'h000, tc=0, IDLE.
- Simultaneous events:
  - clear+start in RUN -> IDLE at 0:00.
  - stop on the wrap cycle -> count increments once, state PAUSE.
  - start+stop in IDLE -> remains IDLE.
- Async reset mid-count:
  - Drop resetN at 12'h347 between clock edges: outputs go to zero immediately, without waiting for an edge.
  - After release, nothing counts until start.
